// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared states, widths and address helper for the mips_np loader.
package mips_loader_pkg;
   localparam int WORD_BYTES = 4;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DUMP, ST_DONE} ld_state_e;
   typedef enum logic [1:0] {DS_IDLE, DS_ADDR, DS_CAP, DS_OUT} dump_state_e;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
      return base + idx * ADDR_W'(WORD_BYTES);
   endfunction
endpackage

// File: rtl/mips_loader_dump.sv
// mips_loader_dump: address/capture/output sequencer streaming a data-memory window.
// The capture cycle between address and output tolerates combinational or 1-cycle reads.
module mips_loader_dump
   import mips_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
   parameter int                DUMP_WORDS = 8
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              start_in,
   input  logic              dump_ready_in,
   input  logic [DATA_W-1:0] read_data_in,
   output logic [ADDR_W-1:0] read_data_address_out,
   output logic              dump_valid_out,
   output logic [DATA_W-1:0] dump_data_out,
   output logic [ADDR_W-1:0] dump_addr_out,
   output logic              done_out
);
   localparam int IW = $clog2(DUMP_WORDS + 1);

   dump_state_e       r_state, w_next;
   logic [IW-1:0]     r_idx;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_addr;
   logic              w_hs, w_last;

   assign dump_valid_out        = (r_state == DS_OUT);
   assign w_hs                  = dump_valid_out && dump_ready_in;
   assign w_last                = (r_idx == IW'(DUMP_WORDS - 1));
   assign done_out              = w_hs && w_last;
   assign read_data_address_out = word_addr(DUMP_BASE, ADDR_W'(r_idx));
   assign dump_data_out         = r_data;
   assign dump_addr_out         = r_addr;

   always_ff @(posedge clock_in or posedge reset_in)
      if (reset_in) r_state <= DS_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         DS_IDLE: w_next = start_in ? DS_ADDR : DS_IDLE;
         DS_ADDR: w_next = DS_CAP;
         DS_CAP:  w_next = DS_OUT;
         DS_OUT:  w_next = !dump_ready_in ? DS_OUT : (w_last ? DS_IDLE : DS_ADDR);
         default: w_next = DS_IDLE;
      endcase
   end

   always_ff @(posedge clock_in or posedge reset_in)
      if (reset_in) begin
         r_idx  <= '0;
         r_data <= '0;
         r_addr <= '0;
      end else begin
         if (r_state == DS_CAP) begin
            r_data <= read_data_in;
            r_addr <= read_data_address_out;
         end
         if (w_hs) r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
endmodule

// File: rtl/mips_loader.sv
// mips_loader: loads a host word stream into mips_np instruction memory under CPU reset,
// runs the CPU for a fixed budget, then streams a data-memory window to the host.
module mips_loader
   import mips_loader_pkg::*;
#(
   parameter int                MAX_WORDS  = 256,
   parameter int                RUN_CYCLES = 1024,
   parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
   parameter int                DUMP_WORDS = 8
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              word_valid_in,
   output logic              word_ready_out,
   input  logic [DATA_W-1:0] word_in,
   input  logic              word_last_in,
   input  logic              start_in,
   output logic              cpu_reset_out,
   output logic              instrWrite_out,
   output logic [ADDR_W-1:0] instr_address_out,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] read_data_address_out,
   input  logic [DATA_W-1:0] read_data_in,
   output logic              dump_valid_out,
   input  logic              dump_ready_in,
   output logic [DATA_W-1:0] dump_data_out,
   output logic [ADDR_W-1:0] dump_addr_out,
   output logic              overflow_out,
   output logic              done_out
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int RW = $clog2(RUN_CYCLES + 1);

   ld_state_e         r_state, w_next;
   logic [CW-1:0]     r_count;
   logic [RW-1:0]     r_run;
   logic              r_write, r_overflow;
   logic [ADDR_W-1:0] r_instr_addr;
   logic [DATA_W-1:0] r_instr;
   logic              w_hs, w_load_end, w_run_end, w_restart, w_dump_done;

   // Ready is gated by reset so no word is accepted while the loader is held.
   assign word_ready_out    = (r_state == ST_LOAD) && !reset_in;
   assign w_hs              = word_valid_in && word_ready_out;
   assign w_load_end        = w_hs && (word_last_in || r_count == CW'(MAX_WORDS - 1));
   assign w_run_end         = (r_state == ST_RUN) && (r_run == RW'(RUN_CYCLES - 1));
   assign w_restart         = (r_state == ST_DONE) && start_in;
   assign cpu_reset_out     = (r_state == ST_LOAD);
   assign instrWrite_out    = r_write;
   assign instr_address_out = r_instr_addr;
   assign instr_out         = r_instr;
   assign overflow_out      = r_overflow;
   assign done_out          = (r_state == ST_DONE);

   always_ff @(posedge clock_in or posedge reset_in)
      if (reset_in) r_state <= ST_LOAD;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (w_load_end) w_next = ST_RUN;
      if (w_run_end) w_next = ST_DUMP;
      if ((r_state == ST_DUMP) && w_dump_done) w_next = ST_DONE;
      if (w_restart) w_next = ST_LOAD;
   end

   always_ff @(posedge clock_in or posedge reset_in)
      if (reset_in) begin
         r_count      <= '0;
         r_run        <= '0;
         r_write      <= 1'b0;
         r_overflow   <= 1'b0;
         r_instr_addr <= '0;
         r_instr      <= '0;
      end else begin
         r_write <= w_hs;
         if (w_hs) begin
            r_instr_addr <= word_addr('0, ADDR_W'(r_count));
            r_instr      <= word_in;
            r_count      <= r_count + 1'b1;
         end
         if (w_load_end && !word_last_in) r_overflow <= 1'b1;
         r_run <= (r_state == ST_RUN) ? r_run + 1'b1 : '0;
         if (w_restart) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
         end
      end

   mips_loader_dump #(
      .DUMP_BASE (DUMP_BASE),
      .DUMP_WORDS(DUMP_WORDS)
   ) u_dump (
      .clock_in             (clock_in),
      .reset_in             (reset_in),
      .start_in             (w_run_end),
      .dump_ready_in        (dump_ready_in),
      .read_data_in         (read_data_in),
      .read_data_address_out(read_data_address_out),
      .dump_valid_out       (dump_valid_out),
      .dump_data_out        (dump_data_out),
      .dump_addr_out        (dump_addr_out),
      .done_out             (w_dump_done)
   );
endmodule

// File: tb/tb_mips_loader.sv
// tb_mips_loader: directed checks of two loader instances against small memory models.
// dut_a: MAX_WORDS=4, DUMP_WORDS=4, combinational read; dut_b: DUMP_WORDS=8, base 0x20, registered read.
module tb_mips_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        vld [2], last [2], start [2], dready [2];
   logic [31:0] wd [2];
   logic        rdy [2], cpur [2], iw [2], dv [2], ovf [2], done [2];
   logic [31:0] iaddr [2], instr [2], raddr [2], ddata [2], daddr [2];
   logic [31:0] rdata0, rdata1;
   logic [31:0] dmem [2][16];
   logic [31:0] wa [2][32];
   logic [31:0] wl [2][32];
   int          nwr [2] = '{0, 0};
   int          ntests = 0, nfail = 0;
   int          n0, k;
   logic [31:0] expv [8];
   logic [31:0] base [2];
   logic [31:0] prog [3];

   always #5 clk = ~clk;

   mips_loader #(.MAX_WORDS(4), .RUN_CYCLES(8), .DUMP_BASE(32'h0), .DUMP_WORDS(4)) dut_a (
      .clock_in(clk), .reset_in(rst), .word_valid_in(vld[0]), .word_ready_out(rdy[0]),
      .word_in(wd[0]), .word_last_in(last[0]), .start_in(start[0]), .cpu_reset_out(cpur[0]),
      .instrWrite_out(iw[0]), .instr_address_out(iaddr[0]), .instr_out(instr[0]),
      .read_data_address_out(raddr[0]), .read_data_in(rdata0), .dump_valid_out(dv[0]),
      .dump_ready_in(dready[0]), .dump_data_out(ddata[0]), .dump_addr_out(daddr[0]),
      .overflow_out(ovf[0]), .done_out(done[0]));

   mips_loader #(.MAX_WORDS(16), .RUN_CYCLES(8), .DUMP_BASE(32'h20), .DUMP_WORDS(8)) dut_b (
      .clock_in(clk), .reset_in(rst), .word_valid_in(vld[1]), .word_ready_out(rdy[1]),
      .word_in(wd[1]), .word_last_in(last[1]), .start_in(start[1]), .cpu_reset_out(cpur[1]),
      .instrWrite_out(iw[1]), .instr_address_out(iaddr[1]), .instr_out(instr[1]),
      .read_data_address_out(raddr[1]), .read_data_in(rdata1), .dump_valid_out(dv[1]),
      .dump_ready_in(dready[1]), .dump_data_out(ddata[1]), .dump_addr_out(daddr[1]),
      .overflow_out(ovf[1]), .done_out(done[1]));

   assign rdata0 = dmem[0][raddr[0][5:2]];
   always @(posedge clk) rdata1 <= dmem[1][raddr[1][5:2]];

   always @(posedge clk)
      for (int d = 0; d < 2; d++)
         if (iw[d] && nwr[d] < 32) begin
            wa[d][nwr[d]] <= iaddr[d];
            wl[d][nwr[d]] <= instr[d];
            nwr[d] <= nwr[d] + 1;
         end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dump_all(input int d, input int n, input int holdw);
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!dv[d] && w < 20) begin
            tick();
            w++;
         end
         chk($sformatf("d%0d_valid_%0d", d, i), dv[d], 1);
         chk($sformatf("d%0d_data_%0d", d, i), ddata[d], expv[i]);
         chk($sformatf("d%0d_addr_%0d", d, i), daddr[d], base[d] + 32'(4 * i));
         if (i == holdw)
            for (int h = 0; h < 5; h++) begin
               tick();
               chk($sformatf("d%0d_hold_valid_%0d", d, h), dv[d], 1);
               chk($sformatf("d%0d_hold_data_%0d", d, h), ddata[d], expv[i]);
               chk($sformatf("d%0d_hold_addr_%0d", d, h), daddr[d], base[d] + 32'(4 * i));
            end
         dready[d] = 1'b1;
         tick();
         dready[d] = 1'b0;
         chk($sformatf("d%0d_valid_drop_%0d", d, i), dv[d], 0);
      end
      chk($sformatf("d%0d_done", d), done[d], 1);
   endtask

   initial begin
      rst = 1'b1;
      base[0] = 32'h0;
      base[1] = 32'h20;
      prog[0] = 32'h20080005;
      prog[1] = 32'h20090003;
      prog[2] = 32'h01095020;
      for (int d = 0; d < 2; d++) begin
         vld[d] = 1'b0; last[d] = 1'b0; start[d] = 1'b0; dready[d] = 1'b0; wd[d] = '0;
         for (int i = 0; i < 16; i++) dmem[d][i] = '0;
      end
      for (int i = 0; i < 4; i++) dmem[0][i] = 32'(i);
      for (int i = 0; i < 8; i++) dmem[1][8 + i] = 32'hA0 + 32'(i);
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_cpur", d), cpur[d], 1);
         chk($sformatf("d%0d_rst_ready", d), rdy[d], 0);
         chk($sformatf("d%0d_rst_iw", d), iw[d], 0);
         chk($sformatf("d%0d_rst_iaddr", d), iaddr[d], 0);
         chk($sformatf("d%0d_rst_instr", d), instr[d], 0);
         chk($sformatf("d%0d_rst_raddr", d), raddr[d], base[d]);
         chk($sformatf("d%0d_rst_valid", d), dv[d], 0);
         chk($sformatf("d%0d_rst_ddata", d), ddata[d], 0);
         chk($sformatf("d%0d_rst_daddr", d), daddr[d], 0);
         chk($sformatf("d%0d_rst_ovf", d), ovf[d], 0);
         chk($sformatf("d%0d_rst_done", d), done[d], 0);
      end
      rst = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_post_rst_ready", d), rdy[d], 1);
         chk($sformatf("d%0d_post_rst_cpur", d), cpur[d], 1);
      end

      // back-to-back load of three words on dut_b
      n0 = nwr[1];
      for (int i = 0; i < 3; i++) begin
         vld[1] = 1'b1; wd[1] = prog[i]; last[1] = (i == 2);
         tick();
         chk($sformatf("b2b_iw_%0d", i), iw[1], 1);
         chk($sformatf("b2b_iaddr_%0d", i), iaddr[1], 32'(4 * i));
         chk($sformatf("b2b_instr_%0d", i), instr[1], prog[i]);
         chk($sformatf("b2b_cpur_%0d", i), cpur[1], (i < 2) ? 32'd1 : 32'd0);
      end
      vld[1] = 1'b0; last[1] = 1'b0;
      chk("b2b_ready_low", rdy[1], 0);
      chk("b2b_ovf", ovf[1], 0);
      tick();
      chk("b2b_iw_off", iw[1], 0);
      chk("b2b_nwrites", 32'(nwr[1] - n0), 3);
      repeat (8) tick();
      chk("run_budget_not_yet", dv[1], 0);
      tick();
      chk("run_budget_first_valid", dv[1], 1);
      for (int i = 0; i < 8; i++) expv[i] = 32'hA0 + 32'(i);
      dump_all(1, 8, -1);

      // restart dut_b, gapped load, then Fibonacci results
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      chk("restart_cpur", cpur[1], 1);
      chk("restart_done", done[1], 0);
      chk("restart_ready", rdy[1], 1);
      n0 = nwr[1];
      for (int i = 0; i < 3; i++) begin
         vld[1] = 1'b1; wd[1] = prog[i] ^ 32'hFF; last[1] = (i == 2);
         tick();
         vld[1] = 1'b0; last[1] = 1'b0;
         chk($sformatf("gap_iw_%0d", i), iw[1], 1);
         chk($sformatf("gap_iaddr_%0d", i), iaddr[1], 32'(4 * i));
         tick();
         chk($sformatf("gap_iw_off_%0d", i), iw[1], 0);
      end
      chk("gap_nwrites", 32'(nwr[1] - n0), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("gap_log_addr_%0d", i), wa[1][n0 + i], 32'(4 * i));
         chk($sformatf("gap_log_data_%0d", i), wl[1][n0 + i], prog[i] ^ 32'hFF);
      end
      expv = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
      for (int i = 0; i < 8; i++) dmem[1][8 + i] = expv[i];
      dump_all(1, 8, -1);

      // overflow on dut_a: six words, no last, MAX_WORDS=4
      n0 = nwr[0];
      for (int i = 0; i < 6; i++) begin
         vld[0] = 1'b1; wd[0] = 32'h1000 + 32'(i); last[0] = 1'b0;
         tick();
         chk($sformatf("ovf_iw_%0d", i), iw[0], (i < 4) ? 32'd1 : 32'd0);
         if (i < 4) chk($sformatf("ovf_iaddr_%0d", i), iaddr[0], 32'(4 * i));
         chk($sformatf("ovf_ready_%0d", i), rdy[0], (i < 3) ? 32'd1 : 32'd0);
         chk($sformatf("ovf_flag_%0d", i), ovf[0], (i < 3) ? 32'd0 : 32'd1);
      end
      vld[0] = 1'b0;
      chk("ovf_nwrites", 32'(nwr[0] - n0), 4);
      for (int i = 0; i < 4; i++) expv[i] = 32'(i);
      dump_all(0, 4, 1);
      chk("ovf_sticky_done", ovf[0], 1);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      chk("ovf_cleared", ovf[0], 0);
      chk("a_restart_done", done[0], 0);
      chk("a_restart_cpur", cpur[0], 1);

      // reset during DUMP_OUT on dut_a
      vld[0] = 1'b1; wd[0] = 32'h0800_0000; last[0] = 1'b1;
      tick();
      vld[0] = 1'b0; last[0] = 1'b0;
      chk("a_single_iaddr", iaddr[0], 0);
      k = 0;
      while (!dv[0] && k < 20) begin
         tick();
         k++;
      end
      chk("a_reach_dump_out", dv[0], 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", dv[0], 0);
      chk("async_rst_cpur", cpur[0], 1);
      chk("async_rst_ready", rdy[0], 0);
      tick();
      rst = 1'b0;
      vld[0] = 1'b1; wd[0] = 32'h3C00_0001; last[0] = 1'b1;
      tick();
      vld[0] = 1'b0; last[0] = 1'b0;
      chk("fresh_iw", iw[0], 1);
      chk("fresh_iaddr", iaddr[0], 0);
      chk("fresh_instr", instr[0], 32'h3C00_0001);
      tick();
      chk("fresh_iw_off", iw[0], 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
